// File: rtl/acs_array.sv
// Add-compare-select array for a radix-2 Viterbi decoder: one ACS per trellis state,
// with shared renormalisation and a lowest-index-wins best-state search.
`timescale 1ns/1ps

module acs_array #(
  parameter int NUM_STATES = 8,
  parameter int METRIC_W   = 8,
  parameter int INIT_BIAS  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          init,
  input  logic                          in_valid,
  input  logic [4*NUM_STATES-1:0]       bmc_flat,
  output logic                          out_valid,
  output logic [NUM_STATES-1:0]         dec_bits,
  output logic [$clog2(NUM_STATES)-1:0] best_state,
  output logic [METRIC_W-1:0]           best_metric,
  output logic                          norm_event
);

  localparam int SW = $clog2(NUM_STATES);

  typedef logic [METRIC_W-1:0] metric_t;

  localparam metric_t SAT_MAX = '1;
  localparam metric_t BIAS    = METRIC_W'(INIT_BIAS);

  metric_t               pm_q [NUM_STATES];
  metric_t               pm_d [NUM_STATES];
  metric_t               sel_pm [NUM_STATES];
  metric_t               norm_pm [NUM_STATES];
  logic [NUM_STATES-1:0] dec_new;
  logic [NUM_STATES-1:0] msb_set;
  logic [NUM_STATES-1:0] sat_flag;
  logic                  all_msb;

  logic                  out_valid_q, out_valid_d;
  logic                  norm_event_q, norm_event_d;
  logic [NUM_STATES-1:0] dec_bits_q, dec_bits_d;
  logic [SW-1:0]         best_state_q, best_state_d;
  metric_t               best_metric_q, best_metric_d;
  logic [SW-1:0]         best_idx;
  metric_t               best_val;

  // Shuffle-exchange trellis: state s is reached from states 2s and 2s+1 (mod N).
  for (genvar s = 0; s < NUM_STATES; s++) begin : g_acs
    localparam int P0 = (2 * s) % NUM_STATES;
    localparam int P1 = (2 * s + 1) % NUM_STATES;

    logic [METRIC_W:0] sum0, sum1;
    metric_t           cand0, cand1;

    assign sum0  = {1'b0, pm_q[P0]} + (METRIC_W+1)'(bmc_flat[4*s +: 2]);
    assign sum1  = {1'b0, pm_q[P1]} + (METRIC_W+1)'(bmc_flat[4*s+2 +: 2]);
    assign cand0 = sum0[METRIC_W] ? SAT_MAX : sum0[METRIC_W-1:0];
    assign cand1 = sum1[METRIC_W] ? SAT_MAX : sum1[METRIC_W-1:0];

    assign sat_flag[s] = sum0[METRIC_W] | sum1[METRIC_W];
    // Strict compare so a tie keeps the p0 survivor.
    assign dec_new[s]  = cand1 < cand0;
    assign sel_pm[s]   = dec_new[s] ? cand1 : cand0;
    assign msb_set[s]  = sel_pm[s][METRIC_W-1];
    assign norm_pm[s]  = {sel_pm[s][METRIC_W-1] & ~all_msb, sel_pm[s][METRIC_W-2:0]};
  end

  assign all_msb = &msb_set;

  always_comb begin
    best_idx = '0;
    best_val = norm_pm[0];
    for (int s = 1; s < NUM_STATES; s++) begin
      if (norm_pm[s] < best_val) begin
        best_val = norm_pm[s];
        best_idx = SW'(s);
      end
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    pm_d          = pm_q;
    dec_bits_d    = dec_bits_q;
    best_state_d  = best_state_q;
    best_metric_d = best_metric_q;
    out_valid_d   = 1'b0;
    norm_event_d  = 1'b0;
    if (init) begin
      for (int s = 0; s < NUM_STATES; s++) pm_d[s] = (s == 0) ? '0 : BIAS;
      dec_bits_d    = '0;
      best_state_d  = '0;
      best_metric_d = '0;
    end else if (in_valid) begin
      pm_d          = norm_pm;
      dec_bits_d    = dec_new;
      best_state_d  = best_idx;
      best_metric_d = best_val;
      out_valid_d   = 1'b1;
      norm_event_d  = all_msb;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: pm is a small flop bank, not a RAM, so it is reset to the frame-start metrics.
      for (int s = 0; s < NUM_STATES; s++) pm_q[s] <= (s == 0) ? '0 : BIAS;
      dec_bits_q    <= '0;
      best_state_q  <= '0;
      best_metric_q <= '0;
      out_valid_q   <= 1'b0;
      norm_event_q  <= 1'b0;
    end else begin
      pm_q          <= pm_d;
      dec_bits_q    <= dec_bits_d;
      best_state_q  <= best_state_d;
      best_metric_q <= best_metric_d;
      out_valid_q   <= out_valid_d;
      norm_event_q  <= norm_event_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign dec_bits    = dec_bits_q;
  assign best_state  = best_state_q;
  assign best_metric = best_metric_q;
  assign norm_event  = norm_event_q;

  // Legal branch metrics (<=2) plus renormalisation keep every sum below saturation.
  a_no_saturation: assert property (@(posedge clk) disable iff (!rst_n)
    (in_valid && !init) |-> !(|sat_flag));

endmodule

// File: tb/tb_acs_array.sv
// Bench for acs_array: a default 8-bit instance and a 4-bit instance for renormalisation,
// both compared every cycle against an arithmetic trellis model.
`timescale 1ns/1ps

module tb_acs_array;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_b = 1'b0, valid_b = 1'b0;
  logic [31:0] bmc_b = '0;
  logic        ov_b, norm_b;
  logic [7:0]  dec_b, bm_b;
  logic [2:0]  bs_b;
  logic        init_s = 1'b0, valid_s = 1'b0;
  logic [31:0] bmc_s = '0;
  logic        ov_s, norm_s;
  logic [7:0]  dec_s;
  logic [3:0]  bm_s;
  logic [2:0]  bs_s;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  acs_array #(.NUM_STATES(8), .METRIC_W(8), .INIT_BIAS(16)) dut (
    .clk(clk), .rst_n(rst_n), .init(init_b), .in_valid(valid_b), .bmc_flat(bmc_b),
    .out_valid(ov_b), .dec_bits(dec_b), .best_state(bs_b), .best_metric(bm_b),
    .norm_event(norm_b));

  acs_array #(.NUM_STATES(8), .METRIC_W(4), .INIT_BIAS(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .init(init_s), .in_valid(valid_s), .bmc_flat(bmc_s),
    .out_valid(ov_s), .dec_bits(dec_s), .best_state(bs_s), .best_metric(bm_s),
    .norm_event(norm_s));

  // Reference model: index 0 is the 8-bit instance, index 1 the 4-bit one.
  int         mpm [2][8];
  logic [7:0] m_dec [2];
  int         m_bs [2];
  int         m_bm [2];
  bit         m_ov [2];
  bit         m_norm [2];
  int         mw [2]    = '{8, 4};
  int         mbias [2] = '{16, 4};

  task automatic model_edge(input int i, input bit ini, input bit v, input logic [31:0] bmc);
    int nm [8];
    int top, half, c0, c1;
    bit all_hi;
    top  = (1 << mw[i]) - 1;
    half = 1 << (mw[i] - 1);
    if (ini) begin
      for (int s = 0; s < 8; s++) mpm[i][s] = (s == 0) ? 0 : mbias[i];
      m_dec[i] = '0; m_bs[i] = 0; m_bm[i] = 0; m_ov[i] = 0; m_norm[i] = 0;
    end else if (v) begin
      all_hi = 1;
      for (int s = 0; s < 8; s++) begin
        c0 = mpm[i][(2*s) % 8] + int'(bmc[4*s +: 2]);
        c1 = mpm[i][(2*s+1) % 8] + int'(bmc[4*s+2 +: 2]);
        if (c0 > top) c0 = top;
        if (c1 > top) c1 = top;
        m_dec[i][s] = (c1 < c0);
        nm[s] = (c1 < c0) ? c1 : c0;
        if (nm[s] < half) all_hi = 0;
      end
      for (int s = 0; s < 8; s++) mpm[i][s] = all_hi ? nm[s] - half : nm[s];
      m_norm[i] = all_hi;
      m_ov[i]   = 1;
      m_bs[i]   = 0;
      m_bm[i]   = mpm[i][0];
      for (int s = 1; s < 8; s++)
        if (mpm[i][s] < m_bm[i]) begin m_bm[i] = mpm[i][s]; m_bs[i] = s; end
    end else begin
      m_ov[i] = 0; m_norm[i] = 0;
    end
  endtask

  function automatic logic [20:0] obs_b();
    return {ov_b, norm_b, bs_b, bm_b, dec_b};
  endfunction
  function automatic logic [20:0] exp_b();
    return {m_ov[0], m_norm[0], 3'(m_bs[0]), 8'(m_bm[0]), m_dec[0]};
  endfunction
  function automatic logic [16:0] obs_s();
    return {ov_s, norm_s, bs_s, bm_s, dec_s};
  endfunction
  function automatic logic [16:0] exp_s();
    return {m_ov[1], m_norm[1], 3'(m_bs[1]), 4'(m_bm[1]), m_dec[1]};
  endfunction

  function automatic logic [31:0] rand_bmc();
    logic [31:0] b;
    for (int f = 0; f < 16; f++) b[2*f +: 2] = 2'($urandom_range(0, 2));
    return b;
  endfunction

  task automatic tick(input bit ib, input bit vb, input logic [31:0] bb,
                      input bit is_, input bit vs, input logic [31:0] bs_);
    init_b = ib; valid_b = vb; bmc_b = bb;
    init_s = is_; valid_s = vs; bmc_s = bs_;
    @(posedge clk); #1;
    model_edge(0, ib, vb, bb);
    model_edge(1, is_, vs, bs_);
  endtask

  task automatic tick_b(input bit ib, input bit vb, input logic [31:0] bb);
    tick(ib, vb, bb, 1'b0, 1'b0, '0);
  endtask

  task automatic apply_reset();
    init_b = 0; valid_b = 0; init_s = 0; valid_s = 0;
    rst_n = 1'b0;
    #1;
    model_edge(0, 1'b1, 1'b0, '0);
    model_edge(1, 1'b1, 1'b0, '0);
    if (obs_b() !== 21'h0) begin
      miscompares++; $display("FAIL reset_outputs_big got=%h exp=0", obs_b());
    end
    vectors++;
    if (obs_s() !== 17'h0) begin
      miscompares++; $display("FAIL reset_outputs_small got=%h exp=0", obs_s());
    end
    vectors++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    tick_b(1'b0, 1'b0, '0);
    if (obs_b() !== exp_b()) begin
      miscompares++; $display("FAIL reset_idle got=%h exp=%h", obs_b(), exp_b());
    end
    vectors++;
  endtask

  task automatic test_zero_symbol();
    tick_b(1'b0, 1'b1, 32'h0);
    if (obs_b() !== exp_b()) begin
      miscompares++; $display("FAIL zero_symbol got=%h exp=%h", obs_b(), exp_b());
    end
    vectors++;
    if ({ov_b, dec_b, bs_b, bm_b} !== {1'b1, 8'h00, 3'd0, 8'd0}) begin
      miscompares++;
      $display("FAIL zero_symbol_fixed got ov=%b dec=%h bs=%0d bm=%0d exp ov=1 dec=00 bs=0 bm=0",
               ov_b, dec_b, bs_b, bm_b);
    end
    vectors++;
  endtask

  task automatic test_error_free();
    tick_b(1'b1, 1'b0, '0);
    for (int k = 0; k < 20; k++) begin
      tick_b(1'b0, 1'b1, 32'h8888_8888);
      if (obs_b() !== exp_b() || dec_b !== 8'h00 || bs_b !== 3'd0 || bm_b !== 8'd0) begin
        miscompares++;
        $display("FAIL error_free sym=%0d got=%h exp=%h", k, obs_b(), exp_b());
      end
      vectors++;
    end
  endtask

  task automatic test_tie();
    logic [31:0] b;
    tick_b(1'b1, 1'b0, '0);
    b = rand_bmc();
    b[15:12] = {2'd1, 2'd1};
    tick_b(1'b0, 1'b1, b);
    if (obs_b() !== exp_b() || dec_b[3] !== 1'b0) begin
      miscompares++; $display("FAIL tie_state3 got=%h exp=%h", obs_b(), exp_b());
    end
    vectors++;
    tick_b(1'b1, 1'b0, '0);
    b = rand_bmc();
    b[15:12] = {2'd0, 2'd1};
    tick_b(1'b0, 1'b1, b);
    if (obs_b() !== exp_b() || dec_b[3] !== 1'b1) begin
      miscompares++; $display("FAIL p1_better_state3 got=%h exp=%h", obs_b(), exp_b());
    end
    vectors++;
  endtask

  task automatic test_normalise();
    tick(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    for (int k = 0; k < 12; k++) begin
      tick(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'hAAAA_AAAA);
      if (obs_s() !== exp_s()) begin
        miscompares++; $display("FAIL norm_all2 sym=%0d got=%h exp=%h", k, obs_s(), exp_s());
      end
      vectors++;
      // From {0,4,..}: 2/6 -> 4/8 -> all 6 -> all 8, which wraps to all 0.
      if (k == 3 && {norm_s, bm_s, bs_s} !== {1'b1, 4'd0, 3'd0}) begin
        miscompares++;
        $display("FAIL norm_fourth got norm=%b bm=%0d bs=%0d exp norm=1 bm=0 bs=0",
                 norm_s, bm_s, bs_s);
      end
      if (k == 3) vectors++;
    end
    for (int k = 0; k < 40; k++) begin
      tick(1'b0, 1'b0, '0, 1'b0, ($urandom_range(0, 3) != 0), rand_bmc());
      if (obs_s() !== exp_s()) begin
        miscompares++; $display("FAIL norm_random sym=%0d got=%h exp=%h", k, obs_s(), exp_s());
      end
      vectors++;
    end
  endtask

  task automatic test_init_midstream();
    for (int k = 0; k < 6; k++) tick_b(1'b0, 1'b1, rand_bmc());
    tick_b(1'b1, 1'b1, rand_bmc());
    if (obs_b() !== exp_b() || ov_b !== 1'b0 || dec_b !== 8'h00) begin
      miscompares++; $display("FAIL init_wins got=%h exp=%h", obs_b(), exp_b());
    end
    vectors++;
    for (int k = 0; k < 3; k++) begin
      tick_b(1'b0, 1'b1, rand_bmc());
      if (obs_b() !== exp_b()) begin
        miscompares++; $display("FAIL after_init sym=%0d got=%h exp=%h", k, obs_b(), exp_b());
      end
      vectors++;
    end
  endtask

  task automatic test_gaps_and_reset();
    for (int k = 0; k < 10; k++) begin
      tick_b(1'b0, 1'b1, rand_bmc());
      if (obs_b() !== exp_b()) begin
        miscompares++; $display("FAIL gap_symbol sym=%0d got=%h exp=%h", k, obs_b(), exp_b());
      end
      vectors++;
      repeat ($urandom_range(1, 5)) begin
        tick_b(1'b0, 1'b0, rand_bmc());
        if (obs_b() !== exp_b()) begin
          miscompares++; $display("FAIL gap_hold sym=%0d got=%h exp=%h", k, obs_b(), exp_b());
        end
        vectors++;
      end
      if (k == 5) apply_reset();
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 30; k++) begin
      tick_b(1'b0, ($urandom_range(0, 4) != 0), rand_bmc());
      if (obs_b() !== exp_b()) begin
        miscompares++; $display("FAIL back_to_back sym=%0d got=%h exp=%h", k, obs_b(), exp_b());
      end
      vectors++;
    end
  endtask

  initial begin
    test_reset();
    test_zero_symbol();
    test_error_free();
    test_tie();
    test_normalise();
    test_init_midstream();
    test_gaps_and_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
